// File: rtl/mult_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
//   - default datapath width and requester count
//   - response-register state encoding
//   - helper to size requester IDs
package mult_sched_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_NUM_REQ = 4;

    // Output register occupancy: EMPTY accepts freely, FULL holds a result.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Minimum ID width able to encode n requesters (at least 1 bit).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/array_multiplier.sv
// Shared combinational multiplier datapath.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   y    : low WIDTH bits of a*b (upper bits discarded)
module array_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a * b;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       : request vector
//   ptr       : highest-priority index (search starts here, wraps to 0)
//   en        : arbitration enable; no grant while low
//   gnt       : one-hot grant (all zero when nothing granted)
//   gnt_idx   : encoded index of the grant (0 when nothing granted)
//   gnt_valid : a grant was issued this cycle
import mult_sched_pkg::*;

module rr_arbiter #(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned ID_W    = DEFAULT_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_valid
);

    int unsigned idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (en) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = (32'(ptr) + off) % NUM_REQ;
                // First hit from ptr upward wins; later hits are ignored.
                if (!gnt_valid && req[idx]) begin
                    gnt[idx]  = 1'b1;
                    gnt_idx   = ID_W'(idx);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : response handshake
//   rsp_y, rsp_id       : registered truncated product and issuing requester
//   busy                : response pending or any request outstanding
import mult_sched_pkg::*;

module mult_rr_scheduler #(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned ID_W    = DEFAULT_ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic               can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;
    logic [WIDTH-1:0]   mul_a, mul_b, mul_y;

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = rsp_valid | (|req_valid);

    // A slot opens either when empty or when the held result leaves this cycle.
    assign can_accept = (state_q == ST_EMPTY) | (rsp_ready & rsp_valid);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (can_accept),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign req_ready = gnt;

    // One-hot AND-OR mux; operands are zero when nothing is granted.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mul_a = mul_a | req_a[i*WIDTH +: WIDTH];
                mul_b = mul_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    array_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    always_comb begin
        state_d  = state_q;
        rsp_y_d  = rsp_y_q;
        rsp_id_d = rsp_id_q;
        ptr_d    = ptr_q;
        if (gnt_valid) begin
            // gnt implies req_valid, so a grant is a completed handshake.
            state_d  = ST_FULL;
            rsp_y_d  = mul_y;
            rsp_id_d = gnt_idx;
            ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (rsp_valid && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rsp_y_q  <= '0;
            rsp_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rsp_y_q  <= rsp_y_d;
            rsp_id_q <= rsp_id_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler (WIDTH=32, NUM_REQ=4).
module tb_mult_rr_scheduler;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_y;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    int n_assert;
    int n_fail;

    mult_rr_scheduler #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [WIDTH-1:0] y, input logic [ID_W-1:0] id);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_y"}, 64'(rsp_y), 64'(y));
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    endtask

    logic [ID_W-1:0]  fair_id [4];
    logic [WIDTH-1:0] fair_y  [4];

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_y", 64'(rsp_y), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request from requester 0
        set_op(0, 32'd6, 32'd9);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("single_ready", 64'(req_ready), 64'b0001);
        chk("single_busy", 64'(busy), 64'd1);
        tick();
        chk_rsp("single", 32'd54, 2'd0);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd0);
        tick();
        chk("single_empty", 64'(rsp_valid), 64'd0);

        // Requester 3 alone (pointer is 1): search wraps, pointer returns to 0
        set_op(3, 32'd3, 32'd5);
        req_valid = 4'b1000;
        #1;
        chk("wrap_ready", 64'(req_ready), 64'b1000);
        tick();
        chk_rsp("wrap", 32'd15, 2'd3);

        // All four valid, back-to-back with the pending response draining
        set_op(0, 32'd14, 32'd12);
        set_op(1, 32'd10, 32'd11);
        set_op(2, 32'd15, 32'd15);
        set_op(3, 32'd6, 32'd9);
        req_valid = 4'b1111;
        #1;
        chk("all_ready0", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("all0", 32'd168, 2'd0);
        req_valid = 4'b1110;
        #1;
        chk("all_ready1", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("all1", 32'd110, 2'd1);
        req_valid = 4'b1100;
        tick();
        chk_rsp("all2", 32'd225, 2'd2);
        req_valid = 4'b1000;
        tick();
        chk_rsp("all3", 32'd54, 2'd3);
        req_valid = 4'b0000;
        tick();
        chk("all_empty", 64'(rsp_valid), 64'd0);

        // Backpressure: first result held while rsp_ready is low
        req_valid = 4'b0011;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("bp_first", 32'd168, 2'd0);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready_hold", 64'(req_ready), 64'd0);
            tick();
            chk_rsp("bp_hold", 32'd168, 2'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("bp_next", 32'd110, 2'd1);

        // Async reset while FULL: cleared before any clock edge
        rsp_ready = 1'b0;
        req_valid = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_y", 64'(rsp_y), 64'd0);
        chk("arst_id", 64'(rsp_id), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fairness: req0 and req2 continuously valid, pointer back at 0
        set_op(0, 32'd3, 32'd4);
        set_op(2, 32'd5, 32'd5);
        fair_id = '{2'd0, 2'd2, 2'd0, 2'd2};
        fair_y  = '{32'd12, 32'd25, 32'd12, 32'd25};
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        #1;
        chk("fair_first_ready", 64'(req_ready), 64'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_rsp("fair", fair_y[k], fair_id[k]);
        end
        req_valid = 4'b0000;
        tick();
        chk("fair_empty", 64'(rsp_valid), 64'd0);

        // Truncation of the product to WIDTH bits
        set_op(1, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b0010;
        #1;
        chk("trunc_ready", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("trunc_zero", 32'h0, 2'd1);
        set_op(3, 32'hFFFF_FFFF, 32'd2);
        req_valid = 4'b1000;
        tick();
        chk_rsp("trunc_ovf", 32'hFFFF_FFFE, 2'd3);
        req_valid = 4'b0000;
        tick();
        chk("final_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one combinational array_multiplier (width WIDTH, truncated WIDTH-bit product) between NUM_REQ requesters.
- Round-robin arbitration, per-requester valid/ready request channels, single registered response channel tagged with requester ID.
- Sits between the operand-producing units and the multiplier datapath; the only block allowed to drive the multiplier operands.

Parameters:
- WIDTH, 32, operand and product width (product = low WIDTH bits of a*b).
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must be >= clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand b, same packing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_y  output  WIDTH  registered product.
- rsp_id  output  ID_W  index of requester that issued the product.
- busy  output  1  high while rsp_valid is high or any req_valid is high.

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rsp_y=0, rsp_id=0, rr pointer=0, req_ready=0. Reset mid-transaction discards the held result; no response is produced for it.
- States: EMPTY (output register empty), FULL (result held, rsp_valid=1).
- can_accept = (state==EMPTY) | (rsp_ready & rsp_valid).
- Grant: when can_accept, grant the first requester with req_valid high, searching from rr pointer upward with wrap at NUM_REQ-1 -> 0. req_ready[g]=1 only for granted g; all others 0. Grant is combinational from current-cycle req_valid.
- On handshake (req_valid[g] & req_ready[g]): the multiplier computes req_a[g]*req_b[g] in the same cycle. On the next clock edge, rsp_y <= product, rsp_id <= g, rsp_valid <= 1, rr pointer <= (g+1) mod NUM_REQ.
- Latency: one cycle from request handshake to rsp_valid. Throughput: one product per cycle while rsp_ready is held high.
- EMPTY -> FULL on a handshake. FULL -> EMPTY on a response handshake with no new request. FULL -> FULL on a response handshake with a simultaneous new request (back-to-back).
- Backpressure: in FULL with rsp_ready=0, req_ready is all zero, and rsp_y/rsp_id/rsp_valid hold stable.
- Requester rules: requesters keep operands stable while req_valid is high and not accepted. Dropping req_valid before acceptance is allowed; that requester is simply skipped.
- No grant when no req_valid is high: the rr pointer is unchanged and the multiplier operands are driven 0.
- Overflow: product bits above WIDTH are discarded silently. Unsigned arithmetic only.
- Fairness: a continuously requesting requester is served within NUM_REQ accepted transactions.

Decomposition:
- Package mult_sched_pkg: default WIDTH/NUM_REQ constants, state encoding (ST_EMPTY, ST_FULL), ID type width helper.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and encoded index.
- Instantiate the existing array_multiplier as the shared datapath (not part of the new RTL).

Test Plan:
- Single request: req0 a=6, b=9, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=54, rsp_id=0; then returns to EMPTY.
- All four requesters valid together, operands (14,12), (10,11), (15,15), (6,9) -> responses on 4 consecutive cycles with ids 0,1,2,3 and y=168,110,225,54.
- Backpressure: rsp_ready=0 after the first result 168 -> rsp_y holds 168 for 5 cycles, req_ready=0 throughout; raising rsp_ready releases the next grant the same cycle.
- Fairness: req0 and req2 continuously valid, pointer=0 -> grants alternate 0,2,0,2.
- Wrap/truncation: a=b=32'h0001_0000 -> rsp_y=0; a=32'hFFFF_FFFF, b=2 -> rsp_y=32'hFFFF_FFFE.
- Async reset asserted while FULL (rsp_valid=1, rsp_y=110) -> rsp_valid=0 and rsp_y=0 immediately, before the next clock edge; after release, the first grant goes to requester 0.
